alucontrol_mdu: RTL and testbench

//  Successor to the 3-bit ALU control decoder, used in the EX stage. Keeps the same aluop/funct -> alucont

---
 rtl/alucontrol_mdu.sv | 226 ++++++++++++++++++++++
 tb/tb_alucontrol_mdu.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alucontrol_mdu.sv
// alucontrol_mdu
//   EX-stage ALU control decoder with an iterative unsigned multiply/divide
//   unit (MULTU / DIVU). The unit owns the HI/LO registers and selects them
//   onto the EX result mux for MFHI / MFLO.
//
//   Optional feature macro: ALUCTL_DIV_EN
//     defined   : DIVU runs through a restoring divider (lo=quotient, hi=remainder)
//     undefined : no divider; DIVU decodes as an unknown funct and never stalls
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   aluop[1:0]        00 add, 01 sub, 1x decode funct
//   funct[5:0]        instruction funct field
//   valid             EX holds a valid instruction
//   flush             pipeline flush, aborts any MDU op in flight
//   srca, srcb        rs / rt operands
//   alucont[2:0]      ALU control (combinational)
//   res_sel[1:0]      EX result select: 00 ALU, 01 HI, 10 LO
//   stall             hold EX and earlier stages
//   hi, lo            HI / LO registers
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | no operation in flight, waiting for MULTU / DIVU
// MUL    | shift-add multiply, one multiplier bit per cycle
// DIV    | restoring divide, one quotient bit per cycle (ALUCTL_DIV_EN)
// DONE   | copy accumulator into hi/lo; instruction retires this cycle

module alucontrol_mdu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       aluop,
   input  logic [5:0]       funct,
   input  logic             valid,
   input  logic             flush,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   output logic [2:0]       alucont,
   output logic [1:0]       res_sel,
   output logic             stall,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MFLO  = 6'b010010;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
`ifdef ALUCTL_DIV_EN
      ,
      S_DIV  = 2'd3
`endif
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   // Shared accumulator: {partial product, multiplier} for MUL,
   // {remainder, dividend/quotient} for DIV. Upper half ends as hi, lower as lo.
   logic [2*WIDTH-1:0] acc_q, acc_d;
   // Multiplicand for MUL, divisor for DIV.
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   logic               is_multu;
   logic               is_divu;
   logic               start;
   logic               busy;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
`ifdef ALUCTL_DIV_EN
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] div_next;
`endif

   // ALU control decode
   always_comb begin
      alucont = 3'b101;
      if (!aluop[1]) begin
         alucont = aluop[0] ? 3'b110 : 3'b010;
      end else begin
         unique case (funct)
            F_ADD:   alucont = 3'b010;
            F_SUB:   alucont = 3'b110;
            F_AND:   alucont = 3'b000;
            F_OR:    alucont = 3'b001;
            F_SLT:   alucont = 3'b111;
            F_MULTU: alucont = 3'b010;
`ifdef ALUCTL_DIV_EN
            F_DIVU:  alucont = 3'b010;
`endif
            default: alucont = 3'b101;
         endcase
      end
   end

   always_comb begin
      res_sel = 2'b00;
      if (aluop[1] && funct == F_MFHI) res_sel = 2'b01;
      if (aluop[1] && funct == F_MFLO) res_sel = 2'b10;
   end

   always_comb begin
      is_multu = aluop[1] & (funct == F_MULTU);
`ifdef ALUCTL_DIV_EN
      is_divu  = aluop[1] & (funct == F_DIVU);
      busy     = (state_q == S_MUL) | (state_q == S_DIV);
`else
      is_divu  = 1'b0;
      busy     = (state_q == S_MUL);
`endif
      // rst_n gating keeps stall low while reset is held with a valid MDU op in EX.
      start = rst_n & valid & (is_multu | is_divu) & (state_q == S_IDLE) & ~flush;
      stall = start | (busy & ~flush);
   end

   // Datapath step functions
   always_comb begin
      // Add the multiplicand to the upper half when the current multiplier
      // bit is set, then shift the whole accumulator right by one.
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_next = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef ALUCTL_DIV_EN
      // Shift the next dividend bit into the remainder, subtract when it fits.
      // A zero divisor always "fits", yielding all-ones quotient and the
      // dividend as remainder without special-casing.
      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd_q};
      if (div_shift >= {1'b0, opnd_q}) begin
         div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
         div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
`endif
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      acc_d   = acc_q;
      opnd_d  = opnd_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               count_d = '0;
               if (is_multu) begin
                  state_d = S_MUL;
                  acc_d   = {{WIDTH{1'b0}}, srcb};
                  opnd_d  = srca;
               end
`ifdef ALUCTL_DIV_EN
               else begin
                  state_d = S_DIV;
                  acc_d   = {{WIDTH{1'b0}}, srca};
                  opnd_d  = srcb;
               end
`endif
            end
         end
         S_MUL: begin
            acc_d   = mul_next;
            count_d = count_q + CNT_W'(1);
            if (count_q == LAST_ITER) state_d = S_DONE;
         end
`ifdef ALUCTL_DIV_EN
         S_DIV: begin
            acc_d   = div_next;
            count_d = count_q + CNT_W'(1);
            if (count_q == LAST_ITER) state_d = S_DONE;
         end
`endif
         S_DONE: begin
            hi_d    = acc_q[2*WIDTH-1:WIDTH];
            lo_d    = acc_q[WIDTH-1:0];
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (flush) begin
         state_d = S_IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         count_q <= '0;
         acc_q   <= '0;
         opnd_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         acc_q   <= acc_d;
         opnd_q  <= opnd_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule

// File: tb/tb_alucontrol_mdu.sv
module tb_alucontrol_mdu;

   localparam int W = 32;
`ifdef ALUCTL_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [1:0]   aluop = 2'b00;
   logic [5:0]   funct = 6'b0;
   logic         valid = 1'b0;
   logic         flush = 1'b0;
   logic [W-1:0] srca = '0;
   logic [W-1:0] srcb = '0;
   logic [2:0]   alucont;
   logic [1:0]   res_sel;
   logic         stall;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   alucontrol_mdu #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .aluop(aluop), .funct(funct), .valid(valid),
      .flush(flush), .srca(srca), .srcb(srcb), .alucont(alucont),
      .res_sel(res_sel), .stall(stall), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      int           cyc;
   } exp_t;

   exp_t         sb_q[$];
   logic [W-1:0] m_hi = '0;
   logic [W-1:0] m_lo = '0;
   int           checks = 0;
   int           errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference result: plain arithmetic operators, independent of the
   // iterative datapath. Pushed to the scoreboard when the op is driven.
   task automatic push_model(input bit is_div, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      logic [2*W-1:0] p;
      if (!is_div) begin
         p = (2*W)'(a) * (2*W)'(b);
         e.hi = p[2*W-1:W];
         e.lo = p[W-1:0];
         e.cyc = W + 1;
      end else if (DIV_EN) begin
         if (b == '0) begin
            e.hi = a;
            e.lo = '1;
         end else begin
            e.hi = a % b;
            e.lo = a / b;
         end
         e.cyc = W + 1;
      end else begin
         e.hi = m_hi;
         e.lo = m_lo;
         e.cyc = 0;
      end
      m_hi = e.hi;
      m_lo = e.lo;
      sb_q.push_back(e);
   endtask

   // Drive one MDU instruction and hold it in EX until it retires (stall low).
   // If has_prev, hi/lo of the previous op are checked in this first cycle.
   task automatic issue(input string tag, input bit is_div, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit has_prev, input exp_t prev,
                        output exp_t res);
      int n;
      push_model(is_div, a, b);
      @(negedge clk);
      valid = 1'b1; aluop = 2'b10; funct = is_div ? F_DIVU : F_MULTU;
      srca = a; srcb = b;
      #1;
      if (has_prev) begin
         chk({tag, "_prev_hi"}, 64'(hi), 64'(prev.hi));
         chk({tag, "_prev_lo"}, 64'(lo), 64'(prev.lo));
      end
      chk({tag, "_alucont"}, 64'(alucont), (is_div && !DIV_EN) ? 64'h5 : 64'h2);
      n = 0;
      while (stall && n < 200) begin
         n++;
         @(negedge clk);
         #1;
      end
      res = sb_q.pop_front();
      chk({tag, "_stall_cycles"}, 64'(n), 64'(res.cyc));
   endtask

   task automatic idle_check(input string tag, input exp_t e);
      @(negedge clk);
      valid = 1'b0; aluop = 2'b00; funct = 6'b0;
      #1;
      chk({tag, "_hi"}, 64'(hi), 64'(e.hi));
      chk({tag, "_lo"}, 64'(lo), 64'(e.lo));
      chk({tag, "_stall_idle"}, 64'(stall), 64'h0);
   endtask

   typedef struct {
      logic [1:0] op;
      logic [5:0] fn;
      logic [2:0] ac;
   } dec_t;

   dec_t dec_tab[10] = '{
      '{2'b10, 6'b100000, 3'b010}, '{2'b10, 6'b100010, 3'b110},
      '{2'b10, 6'b100100, 3'b000}, '{2'b10, 6'b100101, 3'b001},
      '{2'b10, 6'b101010, 3'b111}, '{2'b10, 6'b000000, 3'b101},
      '{2'b00, 6'b100010, 3'b010}, '{2'b00, 6'b111111, 3'b010},
      '{2'b01, 6'b100000, 3'b110}, '{2'b01, 6'b000000, 3'b110}
   };

   exp_t r1, r2, none;

   initial begin
      none.hi = '0; none.lo = '0; none.cyc = 0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_hi", 64'(hi), 64'h0);
      chk("rst_lo", 64'(lo), 64'h0);
      chk("rst_stall", 64'(stall), 64'h0);
      chk("rst_res_sel", 64'(res_sel), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Decode sweep, valid high throughout so stall must stay low
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         valid = 1'b1; aluop = dec_tab[i].op; funct = dec_tab[i].fn;
         #1;
         chk($sformatf("dec%0d_alucont", i), 64'(alucont), 64'(dec_tab[i].ac));
         chk($sformatf("dec%0d_stall", i), 64'(stall), 64'h0);
      end

      // MFHI / MFLO select
      @(negedge clk);
      aluop = 2'b10; funct = 6'b010000;
      #1;
      chk("mfhi_res_sel", 64'(res_sel), 64'h1);
      @(negedge clk);
      funct = 6'b010010;
      #1;
      chk("mflo_res_sel", 64'(res_sel), 64'h2);
      @(negedge clk);
      aluop = 2'b00;
      #1;
      chk("aluop00_res_sel", 64'(res_sel), 64'h0);
      valid = 1'b0;

      // MULTU 0xFFFFFFFF * 2, then MFLO
      issue("mul_max", 1'b0, 32'hFFFF_FFFF, 32'h2, 1'b0, none, r1);
      idle_check("mul_max", r1);
      chk("mul_max_hi_const", 64'(hi), 64'h1);
      chk("mul_max_lo_const", 64'(lo), 64'hFFFF_FFFE);
      @(negedge clk);
      valid = 1'b1; aluop = 2'b10; funct = 6'b010010;
      #1;
      chk("mflo_after_mul", 64'(res_sel), 64'h2);
      chk("mflo_no_stall", 64'(stall), 64'h0);

      // DIVU 100/7 and divide by zero
      issue("div_100_7", 1'b1, 32'd100, 32'd7, 1'b0, none, r1);
      idle_check("div_100_7", r1);
      issue("div_zero", 1'b1, 32'h1234, 32'h0, 1'b0, none, r1);
      idle_check("div_zero", r1);

      // Preload hi/lo (0xAA/0xBB when the divider exists), then flush mid-MULTU
      issue("preload", 1'b1, 32'h0000_BBAA, 32'h100, 1'b0, none, r1);
      idle_check("preload", r1);
      @(negedge clk);
      valid = 1'b1; aluop = 2'b10; funct = F_MULTU; srca = 32'h55; srcb = 32'h77;
      repeat (10) @(negedge clk);
      flush = 1'b1;
      #1;
      chk("flush_stall", 64'(stall), 64'h0);
      @(negedge clk);
      flush = 1'b0; valid = 1'b0; aluop = 2'b00; funct = 6'b0;
      #1;
      chk("flush_after_stall", 64'(stall), 64'h0);
      chk("flush_hi", 64'(hi), 64'(m_hi));
      chk("flush_lo", 64'(lo), 64'(m_lo));
      repeat (W + 3) @(negedge clk);
      #1;
      chk("flush_hi_late", 64'(hi), 64'(m_hi));
      chk("flush_lo_late", 64'(lo), 64'(m_lo));
      issue("post_flush", 1'b0, 32'd12345, 32'd6789, 1'b0, none, r1);
      idle_check("post_flush", r1);

      // Back-to-back: MULTU held through DONE, DIVU the very next cycle
      issue("b2b_mul", 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, none, r1);
      issue("b2b_div", 1'b1, 32'hFEDC_BA98, 32'd1000, 1'b1, r1, r2);
      idle_check("b2b_div", r2);

      // Reset mid-MULTU at T+5
      @(negedge clk);
      valid = 1'b1; aluop = 2'b10; funct = F_MULTU; srca = 32'd9; srcb = 32'd11;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rstmid_stall", 64'(stall), 64'h0);
      chk("rstmid_hi", 64'(hi), 64'h0);
      chk("rstmid_lo", 64'(lo), 64'h0);
      m_hi = '0; m_lo = '0;
      @(negedge clk);
      valid = 1'b0; aluop = 2'b00; funct = 6'b0;
      rst_n = 1'b1;
      #1;
      chk("rstmid_release_stall", 64'(stall), 64'h0);
      repeat (W + 3) @(negedge clk);
      #1;
      chk("rstmid_hi_late", 64'(hi), 64'h0);
      issue("post_rst", 1'b0, 32'd3, 32'd5, 1'b0, none, r1);
      idle_check("post_rst", r1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
